// File: rtl/PARAMS_pkg.sv
// Shared memory-port parameters and the line-controller state encoding.
//   ADDR_SIZE  byte-address width of the word-wide memory port
//   WD_SIZE    memory word width in bits; WD_BYTES bytes per word
//   LINE_SIZE  default cache-line width in bits
package PARAMS_pkg;

  localparam int unsigned ADDR_SIZE = 8;
  localparam int unsigned WD_SIZE   = 32;
  localparam int unsigned WD_BYTES  = WD_SIZE / 8;
  localparam int unsigned LINE_SIZE = 128;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_XFER = 2'd1,
    MC_RESP = 2'd2
  } mem_ctrl_state_t;

endpackage

// File: rtl/mem_line_ctrl.sv
// Cache-line initiator on the word-wide memory port. Accepts one line read or
// write per req handshake, splits it into WORDS word transactions, each holding
// mem_op_en for MEM_LATENCY cycles, and assembles read words into rsp_rdata.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only while idle)
//   req_wr, req_addr, req_wdata  request kind, byte address, write line
//   rsp_valid, rsp_rdata       completion pulse, last read line (natural order)
//   mem_addr, mem_rd_wr, mem_op_en, mem_wr_data, mem_rd_data  memory word port
//
// Build option: MEM_LINE_CTRL_CWF_EN -- reads start at the word addressed by
// req_addr and wrap around the line (critical word first). Undefined: reads
// start at word 0. Writes always run in natural order.
module mem_line_ctrl
  import PARAMS_pkg::*;
#(
  parameter int unsigned LINE_BITS   = LINE_SIZE,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [LINE_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [LINE_BITS-1:0] rsp_rdata,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic                 mem_rd_wr,
  output logic                 mem_op_en,
  output logic [WD_SIZE-1:0]   mem_wr_data,
  input  logic [WD_SIZE-1:0]   mem_rd_data
);

  localparam int unsigned WORDS      = LINE_BITS / WD_SIZE;
  localparam int unsigned LINE_BYTES = LINE_BITS / 8;
  localparam int unsigned IDX_W      = $clog2(WORDS);
  localparam int unsigned LAT_W      = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned WB_W       = $clog2(WD_BYTES);

  localparam logic [ADDR_SIZE-1:0] LINE_MASK = ADDR_SIZE'(LINE_BYTES - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [LAT_W-1:0]     LAST_LAT  = LAT_W'(MEM_LATENCY - 1);

  mem_ctrl_state_t state_q, state_d;

  logic                 wr_q, wr_d;
  logic [ADDR_SIZE-1:0] base_q, base_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [LINE_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_rd_wr_q, mem_rd_wr_d;
  logic                 mem_op_en_q, mem_op_en_d;
  logic [WD_SIZE-1:0]   mem_wr_data_q, mem_wr_data_d;

  logic [ADDR_SIZE-1:0] req_base;
  logic [IDX_W-1:0]     start_idx;

  // Byte address of word idx within the line at base; wraps at top of space.
  function automatic logic [ADDR_SIZE-1:0] word_addr(input logic [ADDR_SIZE-1:0] base,
                                                     input logic [IDX_W-1:0]     idx);
    return base + ADDR_SIZE'(32'(idx) * WD_BYTES);
  endfunction

  function automatic logic [WD_SIZE-1:0] line_word(input logic [LINE_BITS-1:0] line,
                                                   input logic [IDX_W-1:0]     idx);
    return line[32'(idx) * WD_SIZE +: WD_SIZE];
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  assign req_ready = (state_q == MC_IDLE) && !reset;
  assign req_base  = req_addr & ~LINE_MASK;

  // First word of a transfer.
`ifdef MEM_LINE_CTRL_CWF_EN
  assign start_idx = req_wr ? '0 : IDX_W'((req_addr & LINE_MASK) >> WB_W);
`else
  assign start_idx = '0;
`endif

  // Next-state, counters, line buffer and registered port values.
  always_comb begin
    state_d       = state_q;
    wr_d          = wr_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    line_d        = line_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    lat_d         = lat_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_op_en_d   = mem_op_en_q;
    mem_wr_data_d = mem_wr_data_q;

    unique case (state_q)
      MC_IDLE: begin
        if (req_valid && req_ready) begin
          state_d       = MC_XFER;
          wr_d          = req_wr;
          base_d        = req_base;
          wdata_d       = req_wdata;
          idx_d         = start_idx;
          cnt_d         = '0;
          lat_d         = '0;
          mem_op_en_d   = 1'b1;
          mem_rd_wr_d   = req_wr;
          mem_addr_d    = word_addr(req_base, start_idx);
          mem_wr_data_d = line_word(req_wdata, start_idx);
        end
      end

      MC_XFER: begin
        if (lat_q == LAST_LAT) begin
          // Last cycle of the word window: capture read data, then move on.
          if (!wr_q) begin
            line_d[32'(idx_q) * WD_SIZE +: WD_SIZE] = mem_rd_data;
          end
          if (cnt_q == LAST_IDX) begin
            state_d     = MC_RESP;
            mem_op_en_d = 1'b0;
            rsp_valid_d = 1'b1;
            if (!wr_q) begin
              rsp_rdata_d = line_d;
            end
          end else begin
            idx_d         = next_idx(idx_q);
            cnt_d         = cnt_q + IDX_W'(1);
            lat_d         = '0;
            mem_addr_d    = word_addr(base_q, idx_d);
            mem_wr_data_d = line_word(wdata_q, idx_d);
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end

      MC_RESP: begin
        state_d = MC_IDLE;
      end

      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also discards any partial line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MC_IDLE;
      wr_q          <= 1'b0;
      base_q        <= '0;
      wdata_q       <= '0;
      line_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      lat_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_addr_q    <= '0;
      mem_rd_wr_q   <= 1'b0;
      mem_op_en_q   <= 1'b0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      line_q        <= line_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      lat_q         <= lat_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_op_en_q   <= mem_op_en_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_op_en   = mem_op_en_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule
